// File: rtl/adder_pg_stage_pkg.sv
// -----------------------------------------------------------------------------
// adder_pg_stage_pkg
// Shared definitions for the first stage of the parallel-prefix adder:
// default operand/tag widths and the occupancy-state encoding of the
// 2-entry skid buffer.
// -----------------------------------------------------------------------------
package adder_pg_stage_pkg;

  localparam int LEN_DATA_DEF = 32;
  localparam int LEN_TAG_DEF  = 4;

  // Occupancy of the skid buffer (number of beats held).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/adder_pg_stage_pg_entry_calc.sv
// -----------------------------------------------------------------------------
// pg_entry_calc
// Combinational operand conditioning and bitwise generate/propagate/half-sum
// computation for one beat.
// Ports:
//   i_a, i_b  operands
//   i_cin     carry-in (ignored when i_sub = 1)
//   i_sub     1 = compute A - B (B inverted, carry-in forced to 1)
//   o_gen     generate vector, carry-in folded into bit 0
//   o_prop    propagate vector (equal to the half-sum)
//   o_hsum    half-sum vector A ^ B'
// -----------------------------------------------------------------------------
module pg_entry_calc
  import adder_pg_stage_pkg::*;
#(
  parameter int LEN_DATA = LEN_DATA_DEF
) (
  input  logic [LEN_DATA-1:0] i_a,
  input  logic [LEN_DATA-1:0] i_b,
  input  logic                i_cin,
  input  logic                i_sub,
  output logic [LEN_DATA-1:0] o_gen,
  output logic [LEN_DATA-1:0] o_prop,
  output logic [LEN_DATA-1:0] o_hsum
);

  logic [LEN_DATA-1:0] w_b_cond;
  logic [LEN_DATA-1:0] w_hsum;
  logic [LEN_DATA-1:0] w_gen_raw;
  logic                w_c;

  assign w_b_cond  = i_sub ? ~i_b : i_b;
  assign w_c       = i_sub ? 1'b1 : i_cin;
  assign w_hsum    = i_a ^ w_b_cond;
  assign w_gen_raw = i_a & w_b_cond;

  // Folding the carry-in into gen[0] lets the prefix tree run without a
  // separate cin input; prop[0] deliberately stays the plain half-sum bit.
  assign o_gen  = {w_gen_raw[LEN_DATA-1:1], w_gen_raw[0] | (w_hsum[0] & w_c)};
  assign o_prop = w_hsum;
  assign o_hsum = w_hsum;

endmodule

// File: rtl/adder_pg_stage.sv
// -----------------------------------------------------------------------------
// adder_pg_stage
// First pipeline stage of the parallel-prefix adder. Computes per-bit
// generate/propagate/half-sum vectors for each accepted beat and holds them in
// a 2-entry skid buffer (head H drives the outputs, skid S catches the beat
// arriving while downstream stalls). in_ready is a flop, so out_ready never
// reaches in_ready combinationally.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid/in_ready        upstream handshake
//   in_a, in_b, in_cin,
//   in_sub, in_tag           operand beat
//   out_valid/out_ready      downstream handshake
//   gen_out, prop_out,
//   hsum_out, tag_out        fields of the head beat (0 when out_valid = 0)
// -----------------------------------------------------------------------------
module adder_pg_stage
  import adder_pg_stage_pkg::*;
#(
  parameter int LEN_DATA = LEN_DATA_DEF,
  parameter int LEN_TAG  = LEN_TAG_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LEN_DATA-1:0] in_a,
  input  logic [LEN_DATA-1:0] in_b,
  input  logic                in_cin,
  input  logic                in_sub,
  input  logic [LEN_TAG-1:0]  in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LEN_DATA-1:0] gen_out,
  output logic [LEN_DATA-1:0] prop_out,
  output logic [LEN_DATA-1:0] hsum_out,
  output logic [LEN_TAG-1:0]  tag_out
);

  // One buffer entry = {gen, prop, hsum, tag}.
  localparam int LEN_ENT = 3 * LEN_DATA + LEN_TAG;

  logic [LEN_DATA-1:0] w_gen;
  logic [LEN_DATA-1:0] w_prop;
  logic [LEN_DATA-1:0] w_hsum;
  logic [LEN_ENT-1:0]  w_new;

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [LEN_ENT-1:0]  r_h;
  logic [LEN_ENT-1:0]  r_s;
  logic [LEN_ENT-1:0]  w_h_nxt;
  logic [LEN_ENT-1:0]  w_s_nxt;
  logic                w_accept;
  logic                w_consume;

  // Vectors are computed before storage so both entries hold final g/p/hsum.
  pg_entry_calc #(
    .LEN_DATA (LEN_DATA)
  ) u_pg_entry_calc (
    .i_a    (in_a),
    .i_b    (in_b),
    .i_cin  (in_cin),
    .i_sub  (in_sub),
    .o_gen  (w_gen),
    .o_prop (w_prop),
    .o_hsum (w_hsum)
  );

  assign w_new     = {w_gen, w_prop, w_hsum, in_tag};
  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = r_out_valid & out_ready;

  // Next-state and buffer-update decode for the occupancy FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h;
    w_s_nxt     = r_s;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_h_nxt     = w_new;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_accept && !w_consume) begin
          w_state_nxt = ST_FULL;
          w_s_nxt     = w_new;
        end else if (w_consume && !w_accept) begin
          // Clearing H keeps the data outputs at 0 whenever nothing is valid.
          w_state_nxt = ST_EMPTY;
          w_h_nxt     = {LEN_ENT{1'b0}};
        end else if (w_accept && w_consume) begin
          w_state_nxt = ST_ONE;
          w_h_nxt     = w_new;
        end else begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_FULL: begin
        // in_ready is 0 here, so only a consume can happen.
        if (w_consume) begin
          w_state_nxt = ST_ONE;
          w_h_nxt     = r_s;
          w_s_nxt     = {LEN_ENT{1'b0}};
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_h_nxt     = {LEN_ENT{1'b0}};
        w_s_nxt     = {LEN_ENT{1'b0}};
      end
    endcase
  end

  // State, buffer entries and registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_h         <= {LEN_ENT{1'b0}};
      r_s         <= {LEN_ENT{1'b0}};
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_h         <= w_h_nxt;
      r_s         <= w_s_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign gen_out   = r_h[LEN_ENT-1 -: LEN_DATA];
  assign prop_out  = r_h[LEN_ENT-LEN_DATA-1 -: LEN_DATA];
  assign hsum_out  = r_h[LEN_TAG +: LEN_DATA];
  assign tag_out   = r_h[LEN_TAG-1:0];

endmodule

// File: tb/tb_adder_pg_stage.sv
module tb_adder_pg_stage;

  localparam int LD = 8;
  localparam int LT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [LD-1:0] in_a;
  logic [LD-1:0] in_b;
  logic          in_cin;
  logic          in_sub;
  logic [LT-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [LD-1:0] gen_out;
  logic [LD-1:0] prop_out;
  logic [LD-1:0] hsum_out;
  logic [LT-1:0] tag_out;

  always #5 clk = ~clk;

  adder_pg_stage #(.LEN_DATA(LD), .LEN_TAG(LT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .gen_out(gen_out), .prop_out(prop_out), .hsum_out(hsum_out), .tag_out(tag_out)
  );

  typedef struct {
    logic [LD-1:0] a;
    logic [LD-1:0] b;
    logic          cin;
    logic          sub;
    logic [LT-1:0] tag;
  } beat_t;

  typedef struct {
    logic [LD-1:0] a;
    logic [LD-1:0] b;
    logic          cin;
    logic          sub;
    logic [LD-1:0] gen;
    logic [LD-1:0] prop;
    logic [LD-1:0] hsum;
  } vec_t;

  beat_t q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    n_acc = 0;
  bit    mon_en = 1'b0;
  bit    prev_stall = 1'b0;
  logic [3*LD+LT-1:0] prev_fields;

  // Reference: the spec's bit rules for g/p/hsum.
  function automatic logic [3*LD+LT-1:0] model(beat_t bt);
    logic [LD-1:0] bp, hs, g;
    logic          c;
    bp = bt.sub ? ~bt.b : bt.b;
    c  = bt.sub ? 1'b1 : bt.cin;
    hs = bt.a ^ bp;
    g  = bt.a & bp;
    g[0] = g[0] | (hs[0] & c);
    return {g, hs, hs, bt.tag};
  endfunction

  // Reference: plain arithmetic a + b' + c with carry-out.
  function automatic logic [LD:0] arith(beat_t bt);
    logic [LD:0] bp;
    bp = {1'b0, (bt.sub ? ~bt.b : bt.b)};
    return {1'b0, bt.a} + bp + {{LD{1'b0}}, (bt.sub ? 1'b1 : bt.cin)};
  endfunction

  // Sum rebuilt from the DUT's g/p/hsum through a ripple carry chain.
  function automatic logic [LD:0] chain(logic [LD-1:0] g, logic [LD-1:0] p,
                                        logic [LD-1:0] h, logic c);
    logic [LD-1:0] s;
    logic          cy;
    cy = 1'b0;
    for (int i = 0; i < LD; i++) begin
      s[i] = h[i] ^ cy;
      cy   = g[i] | (p[i] & cy);
    end
    s[0] = s[0] ^ c;
    return {cy, s};
  endfunction

  function automatic beat_t rnd_beat(logic [LT-1:0] tag);
    beat_t bt;
    bt.a   = LD'($urandom);
    bt.b   = LD'($urandom);
    bt.cin = 1'($urandom);
    bt.sub = 1'($urandom);
    bt.tag = tag;
    return bt;
  endfunction

  task automatic drive(beat_t bt);
    in_a   = bt.a;
    in_b   = bt.b;
    in_cin = bt.cin;
    in_sub = bt.sub;
    in_tag = bt.tag;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: scoreboard at the falling edge, then return 1 after the rising edge.
  task automatic step();
    beat_t bt;
    logic [3*LD+LT-1:0] cur;
    @(negedge clk);
    cur = {gen_out, prop_out, hsum_out, tag_out};
    if (mon_en) begin
      chk("out_valid_flag", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready_flag", 32'(in_ready), 32'(q.size() != 2));
      if (prev_stall) chk("stall_stable", 32'({out_valid, cur}), 32'({1'b1, prev_fields}));
      prev_stall  = out_valid & !out_ready;
      prev_fields = cur;
      if (out_valid && out_ready && q.size() != 0) begin
        bt = q.pop_front();
        chk("beat_fields", 32'(cur), 32'(model(bt)));
        chk("beat_sum", 32'(chain(gen_out, prop_out, hsum_out, bt.sub ? 1'b1 : bt.cin)),
            32'(arith(bt)));
      end
      if (in_valid && in_ready) begin
        bt.a = in_a; bt.b = in_b; bt.cin = in_cin; bt.sub = in_sub; bt.tag = in_tag;
        q.push_back(bt);
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t  tbl[8];
  beat_t bt0;
  int    cyc;

  initial begin
    tbl[0] = '{8'h0F, 8'h01, 1'b1, 1'b0, 8'h01, 8'h0E, 8'h0E};
    tbl[1] = '{8'h05, 8'h03, 1'b0, 1'b1, 8'h05, 8'hF9, 8'hF9};
    tbl[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h01, 8'hFE, 8'hFE};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 8'hFF, 8'hFF};
    tbl[4] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h01, 8'hFF, 8'hFF};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h80, 8'h00, 8'h00};
    tbl[6] = '{8'h3C, 8'hC3, 1'b0, 1'b1, 8'h3C, 8'h00, 8'h00};
    tbl[7] = '{8'h01, 8'h00, 1'b1, 1'b0, 8'h01, 8'h01, 8'h01};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_fields", 32'({gen_out, prop_out, hsum_out, tag_out}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 chk("rel_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rel_in_ready_high", 32'(in_ready), 32'd1);
    mon_en = 1'b1;

    // Directed table, back-to-back with out_ready = 1
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_a = tbl[i].a; in_b = tbl[i].b; in_cin = tbl[i].cin; in_sub = tbl[i].sub;
      in_tag = LT'(i);
      step();
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_gen", 32'(gen_out), 32'(tbl[i].gen));
      chk("tbl_prop", 32'(prop_out), 32'(tbl[i].prop));
      chk("tbl_hsum", 32'(hsum_out), 32'(tbl[i].hsum));
    end
    in_valid = 1'b0;
    step(); step();
    chk("tbl_drained_fields", 32'({gen_out, prop_out, hsum_out, tag_out}), 32'd0);

    // Skid fill and ordered drain (tags 1, 2, 3)
    out_ready = 1'b0; in_valid = 1'b1;
    drive(rnd_beat(4'd1)); step();
    drive(rnd_beat(4'd2)); step();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head_tag", 32'(tag_out), 32'd1);
    drive(rnd_beat(4'd3)); step(); step();
    chk("held_in_ready", 32'(in_ready), 32'd0);
    chk("held_head_tag", 32'(tag_out), 32'd1);
    out_ready = 1'b1;
    step();
    chk("drain_tag2", 32'(tag_out), 32'd2);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("drain_tag3", 32'(tag_out), 32'd3);
    in_valid = 1'b0;
    step();
    chk("drain_empty", 32'({out_valid, gen_out, prop_out, hsum_out, tag_out}), 32'd0);

    // Reset mid-stream with two beats buffered
    out_ready = 1'b0; in_valid = 1'b1;
    drive(rnd_beat(4'd7)); step();
    drive(rnd_beat(4'd8)); step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_fields", 32'({gen_out, prop_out, hsum_out, tag_out}), 32'd0);
    mon_en = 1'b0; q.delete(); prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("midrst_in_ready_hold", 32'(in_ready), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_rel_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_rel_out_valid", 32'(out_valid), 32'd0);
    mon_en = 1'b1;

    // 100 random beats back-to-back
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(rnd_beat(LT'(i)));
      step();
      chk("b2b_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    step(); step();

    // Random handshake toggling for 10k accepted beats
    n_acc = 0; cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      bt0 = rnd_beat(LT'($urandom));
      drive(bt0);
      step();
      cyc++;
    end
    chk("rand_budget", 32'(n_acc >= 10000), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("rand_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
